// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache-side write buffer.
package cache_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-match address search over the posted-write FIFO, used to forward
// read data that has not yet reached memory.
module wb_match
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t         entries_i [DEPTH],
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [PTR_W-1:0]  head_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        // Walk oldest to youngest so the last match seen is the youngest one.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (valid_i[idx] && (entries_i[idx].addr == addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Posted-write FIFO and req/ack memory sequencer between the cache controller
// and main memory; read misses are forwarded from the FIFO when possible.
module write_buffer
    import cache_pkg::*;
#(
    // Address/data widths come from cache_pkg so wb_entry_t stays consistent.
    parameter int unsigned DEPTH = cache_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cc_rd_en,
    input  logic              cc_wr_en,
    input  logic [ADDR_W-1:0] cc_addr,
    input  logic [DATA_W-1:0] cc_wdata,
    output logic [DATA_W-1:0] cc_rdata,
    output logic              cc_rvalid,
    output logic              cc_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_state_t         state_q;
    wb_entry_t         fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_q;

    logic [DATA_W-1:0] cc_rdata_q;
    logic              cc_rvalid_q, cc_busy_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [DEPTH-1:0]  valid;
    logic [PTR_W-1:0]  off;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              rd_acc, wr_acc, pop;

    // Simultaneous read and write is treated as a read only.
    assign rd_acc = cc_rd_en & ~cc_busy_q;
    assign wr_acc = cc_wr_en & ~cc_rd_en & ~cc_busy_q;
    assign pop    = (state_q == WR) & mem_ack;

    always_comb begin
        valid = '0;
        off   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off      = PTR_W'(i) - rd_ptr_q;
            valid[i] = ({1'b0, off} < count_q);
        end
    end

    wb_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .entries_i (fifo_q),
        .valid_i   (valid),
        .head_i    (rd_ptr_q),
        .addr_i    (cc_addr),
        .hit_o     (hit),
        .data_o    (hit_data)
    );

    always_comb begin
        count_d = count_q;
        if (wr_acc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
        rd_pend_d = rd_pend_q;
        if ((state_q == RD) && mem_ack) begin
            rd_pend_d = 1'b0;
        end else if (rd_acc && !hit) begin
            rd_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            fifo_q[wr_ptr_q] <= {cc_addr, cc_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            cc_rdata_q  <= '0;
            cc_rvalid_q <= 1'b0;
            cc_busy_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            count_q     <= count_d;
            rd_pend_q   <= rd_pend_d;
            cc_busy_q   <= (count_d == CNT_W'(DEPTH)) | rd_pend_d;
            cc_rvalid_q <= 1'b0;
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (rd_acc && !hit) begin
                rd_addr_q <= cc_addr;
            end
            if (rd_acc && hit) begin
                cc_rvalid_q <= 1'b1;
                cc_rdata_q  <= hit_data;
            end
            case (state_q)
                IDLE: begin
                    // A miss accepted this edge has not reached rd_addr_q yet.
                    if (rd_pend_d) begin
                        state_q    <= RD;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= rd_pend_q ? rd_addr_q : cc_addr;
                    end else if (count_q != '0) begin
                        state_q     <= WR;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= fifo_q[rd_ptr_q].addr;
                        mem_wdata_q <= fifo_q[rd_ptr_q].data;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        cc_rvalid_q <= 1'b1;
                        cc_rdata_q  <= mem_rdata;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign cc_rdata  = cc_rdata_q;
    assign cc_rvalid = cc_rvalid_q;
    assign cc_busy   = cc_busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
